dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Load/store controller that sequences every access to the single-port data memory of the out-of-order core. It buffers committed stores in a small in-order store queue and lets speculative loads from the load unit take the memory port. It generates byte enables and lane-aligned write data, and returns sign- or zero-extended load results with their ROB tag one cycle after issue. Loads that overlap a pending store stall until that store has drained.

## Interface
- WIDTH, 31, MSB index of address/data (32-bit words)
- SQ_DEPTH, 4, store-queue entries (power of two, ≥2)
- TAG_W, 5, ROB tag width
- clk  in  1  clock, all state on rising edge
- rstn  in  1  asynchronous, active-low reset
- st_valid / st_ready  in / out  1  committed-store handshake
- st_addr, st_data  in  WIDTH+1  store byte address, unaligned source data
- st_funct3  in  3  000 SB, 001 SH, 010 SW
- st_misalign  out  1  registered one-cycle pulse: the accepted store was misaligned and was discarded
- ld_valid / ld_ready  in / out  1  load-issue handshake
- ld_addr  in  WIDTH+1  load byte address
- ld_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_tag  in  TAG_W  ROB tag
- flush  in  1  cancels a load handshaking in the same cycle
- res_valid  out  1  load result valid, one cycle
- res_tag  out  TAG_W, res_data  out  WIDTH+1, res_misalign  out  1
- sq_empty  out  1  store queue empty
- mem_we  out  1, mem_addr  out  WIDTH+1, mem_bytEnable  out  4, mem_data  out  WIDTH+1  memory port: combinational read, write on the clock edge
- mem_q  in  WIDTH+1  combinational memory read data

## Operation
- Store encode at enqueue, with o = st_addr[1:0]:
  - SB: mask 0001<<o, data = st_data[7:0] replicated ×4.
  - SH: mask 0011<<o, data = st_data[15:0] replicated ×2.
  - SW: mask 1111, data = st_data.
  - Each entry stores word address (addr[WIDTH:2]), mask and data.
- Misaligned store (SH with o[0]=1, SW with o≠0): the store is handshaken but not enqueued, and st_misalign pulses the next cycle.
- st_ready = (count != SQ_DEPTH). There is no enqueue while full, even if the queue drains in the same cycle.
- Hazard: the load word address equals the word address of any valid queue entry, or of a handshaking st_valid store, and the byte masks overlap. Overlap uses the load's own mask: LB/LBU 0001<<o, LH/LHU 0011<<o, LW 1111.
- Port arbitration, one operation per cycle, in priority order:
  - Queue full: drain the head and hold ld_ready=0.
  - ld_valid, no hazard, and a misaligned or aligned load: ld_ready=1 and the load owns the port. A misaligned load never drives the port.
  - Otherwise, queue non-empty: drain the head.
- During a drain: mem_we=1, mem_addr={head word,2'b00}, mem_bytEnable=head mask, mem_data=head data. The head pointer advances.
- ld_ready = !full && !hazard, independent of ld_valid.
- Outside a drain: mem_we=0 and mem_bytEnable=0. mem_addr=ld_addr, mem_data=0.
- Load result is computed from mem_q at the issue cycle, then registered:
  - Byte select mem_q[8o+:8]; halfword select mem_q[16o[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misaligned load (LH/LHU with o[0]=1, LW with o≠0): res_misalign=1, res_data=0.
- flush in cycle N cancels any load handshaking in N: no res_valid in N+1. A res_valid already high in N is unaffected. Stores are never flushed.
- Pointers wrap modulo SQ_DEPTH. count tracks enqueue/drain, and simultaneous enqueue+drain leaves count unchanged.

## Timing
- Reset (rstn low, asynchronous):
  - Head, tail and count go to 0.
  - res_valid, res_misalign, st_misalign, res_tag and res_data go to 0.
  - sq_empty=1, st_ready=1, mem_we=0.
  - Queue contents are discarded, including any reset mid-drain.
- Load latency: handshake in cycle N gives res_valid in N+1 for exactly one cycle. Back-to-back loads give results in consecutive cycles.
- Store enqueued in N drains no earlier than N+1. Drain throughput is 1 per cycle when no loads compete.
- A stalled load is held by the requester until ld_ready. Its hazarding stores drain in order, one per cycle.
- sq_empty = (count==0), from registered state.

## Test plan
- Reset: rstn low mid-drain with 3 entries queued → sq_empty=1, mem_we=0, res_valid=0 immediately. No write occurs after release.
- Byte lanes: SB addr 0x0000_0006, data 0x0000_00A5 → mem_bytEnable=0100, mem_data=0xA5A5_A5A5. Then LB 0x6 → res_data=0xFFFF_FFA5; LBU 0x6 → 0x0000_00A5.
- Hazard: SW 0x10 = 0x1234_5678 queued, then LW 0x10 in the next cycle → ld_ready=0 until the store drains. Result 0x1234_5678 appears one cycle after the load handshake. An LW to 0x14 in the same situation issues immediately.
- Full: 4 stores with ld_valid held → st_ready=0 at count=4, loads stalled, head drained. st_ready rises the cycle after the drain.
- Misalignment: LW 0x3 tag 7 → res_valid next cycle with res_tag=7, res_misalign=1, res_data=0, mem_we=0. SH 0x5 → st_misalign pulse, sq_empty stays 1.
- Flush: LW handshaken with flush=1 → no res_valid next cycle. A queued store still drains.

Source files
------------

// File: rtl/dmem_ctrl_if.sv
// Bundle of the store, load, result and memory-port signals around dmem_ctrl.
// The controller takes the slave view; the core, load unit and memory model take the master view.
interface dmem_ctrl_if #(
    parameter int WIDTH = 31,
    parameter int TAG_W = 5
);
    logic             st_valid;
    logic             st_ready;
    logic [WIDTH:0]   st_addr;
    logic [WIDTH:0]   st_data;
    logic [2:0]       st_funct3;
    logic             st_misalign;

    logic             ld_valid;
    logic             ld_ready;
    logic [WIDTH:0]   ld_addr;
    logic [2:0]       ld_funct3;
    logic [TAG_W-1:0] ld_tag;
    logic             flush;

    logic             res_valid;
    logic [TAG_W-1:0] res_tag;
    logic [WIDTH:0]   res_data;
    logic             res_misalign;

    logic             sq_empty;

    logic             mem_we;
    logic [WIDTH:0]   mem_addr;
    logic [3:0]       mem_bytEnable;
    logic [WIDTH:0]   mem_data;
    logic [WIDTH:0]   mem_q;

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3,
        output st_ready, st_misalign,
        input  ld_valid, ld_addr, ld_funct3, ld_tag, flush,
        output ld_ready,
        output res_valid, res_tag, res_data, res_misalign,
        output sq_empty,
        output mem_we, mem_addr, mem_bytEnable, mem_data,
        input  mem_q
    );

    modport master (
        output st_valid, st_addr, st_data, st_funct3,
        input  st_ready, st_misalign,
        output ld_valid, ld_addr, ld_funct3, ld_tag, flush,
        input  ld_ready,
        input  res_valid, res_tag, res_data, res_misalign,
        input  sq_empty,
        input  mem_we, mem_addr, mem_bytEnable, mem_data,
        output mem_q
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory load/store controller: in-order committed-store queue sharing one memory
// port with speculative loads; loads overlapping a queued store wait for it to drain.
module dmem_ctrl #(
    parameter int WIDTH    = 31,
    parameter int SQ_DEPTH = 4,
    parameter int TAG_W    = 5
) (
    input  logic        clk,
    input  logic        rstn,
    dmem_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(SQ_DEPTH);
    localparam int WA_W  = WIDTH - 1;
    localparam logic [PTR_W:0] FULL_CNT = SQ_DEPTH[PTR_W:0];

    typedef logic [PTR_W-1:0] ptr_t;

    typedef struct packed {
        logic [WA_W-1:0] waddr;
        logic [3:0]      mask;
        logic [WIDTH:0]  data;
    } sq_entry_t;

    sq_entry_t          sq_q [SQ_DEPTH];
    logic [SQ_DEPTH-1:0] vld_q, vld_d;
    ptr_t               head_q, head_d;
    ptr_t               tail_q, tail_d;
    logic [PTR_W:0]     count_q, count_d;

    logic               res_valid_q, res_valid_d;
    logic [TAG_W-1:0]   res_tag_q;
    logic [WIDTH:0]     res_data_q, res_data_d;
    logic               res_mis_q, res_mis_d;
    logic               st_mis_q, st_mis_d;

    logic [1:0]         st_off, ld_off;
    logic [3:0]         st_mask, ld_mask;
    logic [WIDTH:0]     st_word;
    logic               st_mis, ld_mis;
    logic [WA_W-1:0]    st_waddr, ld_waddr;
    logic               full, sq_nempty;
    logic               st_hs, enq, hazard, ld_issue, drain;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;
    logic               unused_st_f3;

    assign unused_st_f3 = bus.st_funct3[2];

    assign st_off   = bus.st_addr[1:0];
    assign ld_off   = bus.ld_addr[1:0];
    assign st_waddr = bus.st_addr[WIDTH:2];
    assign ld_waddr = bus.ld_addr[WIDTH:2];

    // Store lanes: narrow data is replicated so the byte enables alone pick the lane.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        st_mask = 4'b1111;
        st_word = bus.st_data;
        st_mis  = 1'b0;
        case (bus.st_funct3[1:0])
            2'b00: begin
                st_mask = 4'b0001 << st_off;
                st_word = {4{bus.st_data[7:0]}};
            end
            2'b01: begin
                st_mask = 4'b0011 << st_off;
                st_word = {2{bus.st_data[15:0]}};
                st_mis  = st_off[0];
            end
            default: st_mis = (st_off != 2'b00);
        endcase
    end

    always_comb begin
        ld_mask = 4'b1111;
        ld_mis  = 1'b0;
        case (bus.ld_funct3[1:0])
            2'b00:   ld_mask = 4'b0001 << ld_off;
            2'b01: begin
                ld_mask = 4'b0011 << ld_off;
                ld_mis  = ld_off[0];
            end
            default: ld_mis = (ld_off != 2'b00);
        endcase
    end

    assign full      = (count_q == FULL_CNT);
    assign sq_nempty = (count_q != '0);
    assign st_hs     = bus.st_valid && !full;
    assign enq       = st_hs && !st_mis;

    // A load may not bypass any older store that touches one of its bytes,
    // including the store being accepted in this same cycle.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < SQ_DEPTH; i++) begin
            if (vld_q[i] && (sq_q[i].waddr == ld_waddr) && |(sq_q[i].mask & ld_mask))
                hazard = 1'b1;
        end
        if (st_hs && (st_waddr == ld_waddr) && |(st_mask & ld_mask))
            hazard = 1'b1;
    end

    assign ld_issue = bus.ld_valid && !full && !hazard;
    assign drain    = sq_nempty && !ld_issue;

    assign bus.st_ready      = !full;
    assign bus.ld_ready      = !full && !hazard;
    assign bus.sq_empty      = !sq_nempty;
    assign bus.mem_we        = drain;
    assign bus.mem_addr      = drain ? {sq_q[head_q].waddr, 2'b00} : bus.ld_addr;
    assign bus.mem_bytEnable = drain ? sq_q[head_q].mask : 4'b0000;
    assign bus.mem_data      = drain ? sq_q[head_q].data : '0;

    assign ld_byte = bus.mem_q[{ld_off, 3'b000} +: 8];
    assign ld_half = bus.mem_q[{ld_off[1], 4'b0000} +: 16];

    always_comb begin
        res_valid_d = ld_issue && !bus.flush;
        res_mis_d   = ld_mis;
        case (bus.ld_funct3)
            3'b000:  res_data_d = {{(WIDTH-6){ld_byte[7]}}, ld_byte};
            3'b001:  res_data_d = {{(WIDTH-14){ld_half[15]}}, ld_half};
            3'b100:  res_data_d = {{(WIDTH-6){1'b0}}, ld_byte};
            3'b101:  res_data_d = {{(WIDTH-14){1'b0}}, ld_half};
            default: res_data_d = bus.mem_q;
        endcase
        if (ld_mis)
            res_data_d = '0;
    end

    always_comb begin
        head_d   = drain ? head_q + ptr_t'(1) : head_q;
        tail_d   = enq   ? tail_q + ptr_t'(1) : tail_q;
        count_d  = count_q;
        case ({enq, drain})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        vld_d = vld_q;
        if (drain)
            vld_d[head_q] = 1'b0;
        if (enq)
            vld_d[tail_q] = 1'b1;
        st_mis_d = st_hs && st_mis;
    end

    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            vld_q       <= '0;
            res_valid_q <= 1'b0;
            res_tag_q   <= '0;
            res_data_q  <= '0;
            res_mis_q   <= 1'b0;
            st_mis_q    <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            vld_q       <= vld_d;
            res_valid_q <= res_valid_d;
            st_mis_q    <= st_mis_d;
            if (ld_issue) begin
                res_tag_q  <= bus.ld_tag;
                res_data_q <= res_data_d;
                res_mis_q  <= res_mis_d;
            end
        end
    end

    // NOTE: queue storage is not reset; vld_q and count_q gate every use of it.
    always_ff @(posedge clk) begin
        if (enq)
            sq_q[tail_q] <= '{waddr: st_waddr, mask: st_mask, data: st_word};
    end

    assign bus.res_valid    = res_valid_q;
    assign bus.res_tag      = res_tag_q;
    assign bus.res_data     = res_data_q;
    assign bus.res_misalign = res_mis_q;
    assign bus.st_misalign  = st_mis_q;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: directed stores/loads with hand-computed results,
// a byte-enabled memory model, and a monitor that checks every load result against a queue.
module tb_dmem_ctrl;
    logic clk;
    logic rstn;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   wr_count = 0;

    typedef struct {
        logic [4:0]  tag;
        logic [31:0] data;
        logic        mis;
        int          due;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem [32] = '{5: 32'hCAFE_F00D, 6: 32'h8001_7F80, default: 32'h0};

    dmem_ctrl_if #(.WIDTH(31), .TAG_W(5)) bus ();

    dmem_ctrl #(.WIDTH(31), .SQ_DEPTH(4), .TAG_W(5)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign bus.mem_q = mem[bus.mem_addr[6:2]];

    always @(posedge clk) begin
        if (bus.mem_we) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_bytEnable[b])
                    mem[bus.mem_addr[6:2]][8*b +: 8] <= bus.mem_data[8*b +: 8];
            wr_count <= wr_count + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every result the DUT presents must match the oldest expected entry.
    always @(negedge clk) begin
        if (rstn && bus.res_valid) begin
            if (sb.size() == 0) begin
                check("res_unexpected", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_tag",      {27'd0, bus.res_tag}, {27'd0, e.tag});
                check("res_data",     bus.res_data, e.data);
                check("res_misalign", {31'd0, bus.res_misalign}, {31'd0, e.mis});
                check("res_cycle",    cyc, e.due);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        bus.st_valid  = 1'b1;
        bus.st_addr   = a;
        bus.st_data   = d;
        bus.st_funct3 = f3;
        @(negedge clk);
        for (int i = 0; i < 32 && !bus.st_ready; i++) @(negedge clk);
        if (!bus.st_ready) check("st_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic st_idle();
        bus.st_valid = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [2:0] f3, input logic [4:0] tag,
                           input logic fl, input logic [31:0] exp_d, input logic exp_m,
                           output int stall, output logic we_hs);
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = a;
        bus.ld_funct3 = f3;
        bus.ld_tag    = tag;
        bus.flush     = fl;
        stall = 0;
        @(negedge clk);
        while (!bus.ld_ready && stall < 32) begin
            stall++;
            @(negedge clk);
        end
        we_hs = bus.mem_we;
        if (!bus.ld_ready)
            check("ld_timeout", 32'd0, 32'd1);
        else if (!fl)
            sb.push_back('{tag: tag, data: exp_d, mis: exp_m, due: cyc + 1});
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic ld_idle();
        bus.ld_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    int   stall;
    logic we_hs;
    int   wr_snap;

    initial begin
        rstn          = 1'b0;
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.st_funct3 = 3'b010;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_funct3 = 3'b010;
        bus.ld_tag    = '0;
        bus.flush     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sq_empty",  {31'd0, bus.sq_empty},  32'd1);
        check("rst_st_ready",  {31'd0, bus.st_ready},  32'd1);
        check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},    32'd0);
        check("rst_st_mis",    {31'd0, bus.st_misalign}, 32'd0);
        @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Byte lanes: SB then signed/unsigned byte loads of the same byte.
        do_store(32'h6, 32'h0000_00A5, 3'b000);
        st_idle();
        @(negedge clk);
        check("sb_mem_we",   {31'd0, bus.mem_we}, 32'd1);
        check("sb_mem_addr", bus.mem_addr, 32'h4);
        check("sb_be",       {28'd0, bus.mem_bytEnable}, 32'h4);
        check("sb_data",     bus.mem_data, 32'hA5A5_A5A5);
        @(posedge clk);
        #1;
        do_load(32'h6, 3'b000, 5'd1, 1'b0, 32'hFFFF_FFA5, 1'b0, stall, we_hs);
        do_load(32'h6, 3'b100, 5'd2, 1'b0, 32'h0000_00A5, 1'b0, stall, we_hs);
        ld_idle();

        // Halfword store lanes, then back-to-back loads of every size.
        do_store(32'h1E, 32'h0000_BEEF, 3'b001);
        st_idle();
        @(negedge clk);
        check("sh_mem_addr", bus.mem_addr, 32'h1C);
        check("sh_be",       {28'd0, bus.mem_bytEnable}, 32'hC);
        check("sh_data",     bus.mem_data, 32'hBEEF_BEEF);
        @(posedge clk);
        #1;
        do_load(32'h1E, 3'b101, 5'd10, 1'b0, 32'h0000_BEEF, 1'b0, stall, we_hs);
        do_load(32'h1E, 3'b001, 5'd11, 1'b0, 32'hFFFF_BEEF, 1'b0, stall, we_hs);
        do_load(32'h18, 3'b001, 5'd12, 1'b0, 32'h0000_7F80, 1'b0, stall, we_hs);
        do_load(32'h1A, 3'b001, 5'd13, 1'b0, 32'hFFFF_8001, 1'b0, stall, we_hs);
        do_load(32'h1A, 3'b101, 5'd14, 1'b0, 32'h0000_8001, 1'b0, stall, we_hs);
        do_load(32'h19, 3'b000, 5'd15, 1'b0, 32'h0000_007F, 1'b0, stall, we_hs);
        do_load(32'h18, 3'b000, 5'd16, 1'b0, 32'hFFFF_FF80, 1'b0, stall, we_hs);
        do_load(32'h18, 3'b010, 5'd17, 1'b0, 32'h8001_7F80, 1'b0, stall, we_hs);
        ld_idle();

        // Hazard: overlapping load waits exactly for the one drain.
        do_store(32'h10, 32'h1234_5678, 3'b010);
        st_idle();
        do_load(32'h10, 3'b010, 5'd3, 1'b0, 32'h1234_5678, 1'b0, stall, we_hs);
        ld_idle();
        check("hazard_stall", stall, 32'd1);

        // Non-overlapping word issues at once and the store drains afterwards.
        do_store(32'h10, 32'h0BAD_BEEF, 3'b010);
        st_idle();
        do_load(32'h14, 3'b010, 5'd4, 1'b0, 32'hCAFE_F00D, 1'b0, stall, we_hs);
        check("nohazard_stall", stall, 32'd0);
        do_load(32'h10, 3'b010, 5'd5, 1'b0, 32'h0BAD_BEEF, 1'b0, stall, we_hs);
        ld_idle();

        // Hazard against a store handshaking in the same cycle.
        bus.st_valid  = 1'b1;
        bus.st_addr   = 32'h20;
        bus.st_data   = 32'h0000_0077;
        bus.st_funct3 = 3'b010;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h20;
        bus.ld_funct3 = 3'b010;
        @(negedge clk);
        check("same_cycle_hazard", {31'd0, bus.ld_ready}, 32'd0);
        @(posedge clk);
        #1;
        st_idle();
        do_load(32'h20, 3'b010, 5'd6, 1'b0, 32'h0000_0077, 1'b0, stall, we_hs);
        ld_idle();
        check("same_cycle_stall", stall, 32'd1);

        // Misalignment: load returns zero with the flag; store is discarded.
        do_load(32'h3, 3'b010, 5'd7, 1'b0, 32'h0, 1'b1, stall, we_hs);
        check("mis_ld_we", {31'd0, we_hs}, 32'd0);
        do_load(32'h5, 3'b101, 5'd8, 1'b0, 32'h0, 1'b1, stall, we_hs);
        ld_idle();
        do_store(32'h5, 32'h0000_1234, 3'b001);
        st_idle();
        @(negedge clk);
        check("mis_st_pulse", {31'd0, bus.st_misalign}, 32'd1);
        check("mis_st_empty", {31'd0, bus.sq_empty}, 32'd1);
        check("mis_st_we",    {31'd0, bus.mem_we}, 32'd0);
        @(negedge clk);
        check("mis_st_pulse_end", {31'd0, bus.st_misalign}, 32'd0);
        @(posedge clk);
        #1;

        // Flush: cancelled load gives no result; the queued store still drains.
        do_store(32'h50, 32'h55AA_55AA, 3'b010);
        st_idle();
        do_load(32'h54, 3'b010, 5'd9, 1'b1, 32'h0, 1'b0, stall, we_hs);
        ld_idle();
        @(negedge clk);
        check("flush_no_res",  {31'd0, bus.res_valid}, 32'd0);
        check("flush_drain",   {31'd0, bus.mem_we}, 32'd1);
        check("flush_drain_a", bus.mem_addr, 32'h50);
        @(posedge clk);
        #1;

        // Full queue: a held (flushed) load starves the drain until count hits 4.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h30;
        bus.ld_funct3 = 3'b010;
        bus.flush     = 1'b1;
        for (int i = 0; i < 4; i++)
            do_store(32'h40 + 32'(4 * i), 32'h1111_0000 + 32'(i), 3'b010);
        st_idle();
        @(negedge clk);
        check("full_st_ready", {31'd0, bus.st_ready}, 32'd0);
        check("full_ld_ready", {31'd0, bus.ld_ready}, 32'd0);
        check("full_drain",    {31'd0, bus.mem_we}, 32'd1);
        check("full_drain_a",  bus.mem_addr, 32'h40);
        check("full_drain_d",  bus.mem_data, 32'h1111_0000);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("after_full_st_ready", {31'd0, bus.st_ready}, 32'd1);
        check("after_full_ld_owns",  {31'd0, bus.mem_we}, 32'd0);
        @(posedge clk);
        #1;
        ld_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("full_drained_empty", {31'd0, bus.sq_empty}, 32'd1);
        for (int i = 0; i < 4; i++)
            check("full_mem_word", mem[16 + i], 32'h1111_0000 + 32'(i));
        check("flush_mem_word", mem[20], 32'h55AA_55AA);
        check("hazard_mem_word", mem[4], 32'h0BAD_BEEF);
        @(posedge clk);
        #1;

        // Reset mid-drain with three stores queued: nothing may be written afterwards.
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 32'h30;
        bus.ld_funct3 = 3'b010;
        bus.flush     = 1'b1;
        for (int i = 0; i < 3; i++)
            do_store(32'h60 + 32'(4 * i), 32'h2222_0000 + 32'(i), 3'b010);
        st_idle();
        ld_idle();
        #2;
        check("pre_rst_drain", {31'd0, bus.mem_we}, 32'd1);
        rstn = 1'b0;
        #1;
        check("rst_mid_sq_empty",  {31'd0, bus.sq_empty},  32'd1);
        check("rst_mid_mem_we",    {31'd0, bus.mem_we},    32'd0);
        check("rst_mid_res_valid", {31'd0, bus.res_valid}, 32'd0);
        wr_snap = wr_count;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_no_writes",   wr_count, wr_snap);
        check("rst_word_intact", mem[24], 32'h0);
        check("rst_st_ready_after", {31'd0, bus.st_ready}, 32'd1);

        repeat (3) @(negedge clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
